// File: rtl/tmr_irq_ctrl_v1_pkg.sv
// tmr_irq_ctrl_v1_pkg: register layouts, FSM states, access masks and priority helper
package tmr_irq_ctrl_v1_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR} tmr_irq_state_e;
  typedef struct packed {
    logic match1;
    logic match0;
    logic ovf;
  } tmr_irq_stat_t;
  typedef struct packed {
    logic gie;
    logic match1;
    logic match0;
    logic ovf;
  } tmr_irq_en_t;
  typedef struct packed {
    logic [7:0] match1;
    logic [7:0] match0;
    logic [7:0] ovf;
  } tmr_irq_cnt_t;
  localparam logic [31:0] STAT_RD_MASK = 32'h0000_0007;
  localparam logic [31:0] STAT_WR_MASK = 32'h0000_0007;
  localparam logic [31:0] EN_RD_MASK = 32'h0000_0107;
  localparam logic [31:0] EN_WR_MASK = 32'h0000_0107;
  localparam logic [31:0] CNT_RD_MASK = 32'h00FF_FFFF;
  function automatic logic [1:0] prio_id(input logic [2:0] p);
    return p[0] ? 2'd0 : p[1] ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/tmr_irq_ctrl_v1_if.sv
// tmr_irq_ctrl_v1_if: SFR bus plus interrupt request/acknowledge handshake
interface tmr_irq_ctrl_v1_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] sys_addr;
  logic sys_wr_en;
  logic [DATA_WIDTH-1:0] sys_sw_value;
  logic [DATA_WIDTH-1:0] sfr_rd_dout;
  logic irq_ack;
  logic irq_req;
  logic [1:0] irq_id;
  modport master (output sys_addr, sys_wr_en, sys_sw_value, irq_ack, input sfr_rd_dout, irq_req, irq_id);
  modport slave (input sys_addr, sys_wr_en, sys_sw_value, irq_ack, output sfr_rd_dout, irq_req, irq_id);
endinterface

// File: rtl/tmr_irq_ctrl_v1_evt_rise_det.sv
// evt_rise_det_v1: one-shot rise detector for a level event, masked on the first cycle after reset
module evt_rise_det_v1 (
  input logic clk,
  input logic rst,
  input logic en,
  input logic evt,
  output logic rise
);
  logic evt_q, armed;
  // remember the previous level and open the mask after the first enabled cycle
  always_ff @(posedge clk)
    if (rst) begin
      evt_q <= 1'b0;
      armed <= 1'b0;
    end else if (en) begin
      evt_q <= evt;
      armed <= 1'b1;
    end
  assign rise = evt & ~evt_q & armed;
endmodule

// File: rtl/tmr_irq_ctrl_v1.sv
// tmr_irq_ctrl_v1: timer event flags, saturating counters and a prioritised acknowledged IRQ
module tmr_irq_ctrl_v1
  import tmr_irq_ctrl_v1_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int CNT_WIDTH = 8
) (
  input logic sys_clk,
  input logic sys_rst,
  input logic sys_clk_en,
  input logic match0_event,
  input logic match1_event,
  input logic ovf_event,
  tmr_irq_ctrl_v1_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] EN_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [7:0] CNT_MAX = 8'((9'd1 << CNT_WIDTH) - 9'd1);
  logic [2:0] evt, rise, pend;
  logic wr_stat, wr_irq_en, wr_cnt, req, req_d;
  logic [1:0] id, id_d;
  logic [DATA_WIDTH-1:0] en_w;
  tmr_irq_state_e state, state_d;
  tmr_irq_stat_t stat, stat_d;
  tmr_irq_en_t en, en_d;
  tmr_irq_cnt_t cnt, cnt_d;
  function automatic logic [7:0] cnt_next(input logic [7:0] c, input logic r, input logic clr);
    return clr ? {7'd0, r} : (r && c != CNT_MAX) ? c + 8'd1 : c;
  endfunction
  assign evt = {match1_event, match0_event, ovf_event};
  for (genvar i = 0; i < 3; i++) begin : g_det
    evt_rise_det_v1 u_det (.clk(sys_clk), .rst(sys_rst), .en(sys_clk_en), .evt(evt[i]), .rise(rise[i]));
  end
  assign wr_stat = bus.sys_wr_en && bus.sys_addr == BASE_ADDR;
  assign wr_irq_en = bus.sys_wr_en && bus.sys_addr == EN_ADDR;
  assign wr_cnt = bus.sys_wr_en && bus.sys_addr == CNT_ADDR;
  assign en_w = bus.sys_sw_value & DATA_WIDTH'(EN_WR_MASK);
  assign stat_d = tmr_irq_stat_t'(({stat} & ~(wr_stat ? bus.sys_sw_value[2:0] & STAT_WR_MASK[2:0] : 3'b0)) | rise);
  assign en_d = wr_irq_en ? tmr_irq_en_t'({en_w[8], en_w[2:0]}) : en;
  assign cnt_d = tmr_irq_cnt_t'({cnt_next(cnt.match1, rise[2], wr_cnt),
                                 cnt_next(cnt.match0, rise[1], wr_cnt),
                                 cnt_next(cnt.ovf, rise[0], wr_cnt)});
  assign pend = {stat} & en[2:0];
  assign bus.irq_req = req;
  assign bus.irq_id = id;
  assign bus.sfr_rd_dout = bus.sys_addr == BASE_ADDR ? DATA_WIDTH'({stat}) & DATA_WIDTH'(STAT_RD_MASK) :
                           bus.sys_addr == EN_ADDR ? DATA_WIDTH'({en.gie, 5'd0, en[2:0]}) & DATA_WIDTH'(EN_RD_MASK) :
                           bus.sys_addr == CNT_ADDR ? DATA_WIDTH'({cnt}) & DATA_WIDTH'(CNT_RD_MASK) : '0;
  // request on the highest pending source; a withdraw looks at this cycle's writes so it beats a same-cycle ack
  always_comb begin
    state_d = state;
    req_d = req;
    id_d = id;
    case (state)
      IDLE: if (en.gie && |pend) begin
        state_d = REQ;
        req_d = 1'b1;
        id_d = prio_id(pend);
      end
      REQ: if (!en_d.gie || !stat_d[id] || !en_d[id]) begin
        state_d = IDLE;
        req_d = 1'b0;
      end else if (bus.irq_ack) begin
        state_d = WAIT_CLR;
        req_d = 1'b0;
      end
      WAIT_CLR: state_d = stat[id] ? WAIT_CLR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // all state advances only on enabled cycles
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      stat <= '0;
      en <= '0;
      cnt <= '0;
      req <= 1'b0;
      id <= 2'd0;
    end else if (sys_clk_en) begin
      state <= state_d;
      stat <= stat_d;
      en <= en_d;
      cnt <= cnt_d;
      req <= req_d;
      id <= id_d;
    end
endmodule

// File: tb/tb_tmr_irq_ctrl_v1.sv
// tb_tmr_irq_ctrl_v1: directed plus randomized check of the timer IRQ controller against a behavioural model
module tb_tmr_irq_ctrl_v1;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int CMAX = 255;
  logic clk = 1'b0;
  logic rst, clk_en, m0, m1, ov;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  tmr_irq_ctrl_v1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  tmr_irq_ctrl_v1 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(BASE), .CNT_WIDTH(8)) dut (
    .sys_clk(clk), .sys_rst(rst), .sys_clk_en(clk_en),
    .match0_event(m0), .match1_event(m1), .ovf_event(ov), .bus(bus)
  );
  bit mp[3], ms[3], me[3];
  bit marm, mg, mreq, mwait;
  int mc[3];
  int mid;
  always @(posedge clk) begin : model
    bit r[3], ns[3], ne[3];
    bit ng, ws, we, wc;
    int pid;
    logic [2:0] e;
    logic [31:0] w;
    e = {m1, m0, ov};
    w = bus.sys_sw_value;
    ws = bus.sys_wr_en && bus.sys_addr == BASE;
    we = bus.sys_wr_en && bus.sys_addr == BASE + 32'd4;
    wc = bus.sys_wr_en && bus.sys_addr == BASE + 32'd8;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mp[i] = 0; ms[i] = 0; me[i] = 0; mc[i] = 0;
      end
      marm = 0; mg = 0; mreq = 0; mwait = 0; mid = 0;
    end else if (clk_en) begin
      for (int i = 0; i < 3; i++) begin
        r[i] = e[i] && !mp[i] && marm;
        ns[i] = (ms[i] && !(ws && w[i])) || r[i];
        ne[i] = we ? w[i] : me[i];
      end
      ng = we ? w[8] : mg;
      pid = -1;
      for (int i = 2; i >= 0; i--) if (ms[i] && me[i]) pid = i;
      if (mreq) begin
        if (!ng || !ns[mid] || !ne[mid]) mreq = 0;
        else if (bus.irq_ack) begin mreq = 0; mwait = 1; end
      end else if (mwait) begin
        if (!ms[mid]) mwait = 0;
      end else if (mg && pid >= 0) begin
        mreq = 1; mid = pid;
      end
      for (int i = 0; i < 3; i++) begin
        mc[i] = wc ? int'(r[i]) : (r[i] && mc[i] < CMAX) ? mc[i] + 1 : mc[i];
        ms[i] = ns[i]; me[i] = ne[i]; mp[i] = e[i];
      end
      mg = ng;
      marm = 1;
    end
  end
  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == BASE) return {29'd0, ms[2], ms[1], ms[0]};
    if (a == BASE + 32'd4) return {23'd0, mg, 5'd0, me[2], me[1], me[0]};
    if (a == BASE + 32'd8) return {8'd0, 8'(mc[2]), 8'(mc[1]), 8'(mc[0])};
    return 32'd0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("irq_req", {31'd0, bus.irq_req}, {31'd0, mreq});
    chk("irq_id", {30'd0, bus.irq_id}, 32'(mid));
    chk("sfr_rd_dout", bus.sfr_rd_dout, exp_rd(bus.sys_addr));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.sys_addr = a;
    bus.sys_sw_value = d;
    bus.sys_wr_en = 1'b1;
    tick();
    bus.sys_wr_en = 1'b0;
  endtask
  task automatic ack();
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
  endtask
  task automatic rd_lit(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.sys_addr = a;
    #1;
    chk(nm, bus.sfr_rd_dout, exp);
  endtask
  task automatic lit_req(input string nm, input logic r, input logic [1:0] id);
    chk({nm, "_req"}, {31'd0, bus.irq_req}, {31'd0, r});
    chk({nm, "_id"}, {30'd0, bus.irq_id}, {30'd0, id});
  endtask
  initial begin
    int sel;
    logic [31:0] d;
    rst = 1; clk_en = 1; ov = 0; m0 = 0; m1 = 0;
    bus.sys_addr = BASE; bus.sys_wr_en = 0; bus.sys_sw_value = 0; bus.irq_ack = 0;
    tick(); tick();
    rst = 0;
    chk_on = 1;
    lit_req("rst", 0, 0);
    rd_lit("rst_stat", BASE, 0);
    rd_lit("rst_en", BASE + 4, 0);
    rd_lit("rst_cnt", BASE + 8, 0);
    rd_lit("unmapped", BASE + 12, 0);
    wr(BASE + 4, 32'hFFFF_FFFF);
    rd_lit("en_mask", BASE + 4, 32'h107);
    ov = 1; tick();
    lit_req("ovf_n1", 0, 0);
    rd_lit("ovf_stat", BASE, 1);
    tick();
    lit_req("ovf_n2", 1, 0);
    repeat (14) tick();
    rd_lit("ovf_cnt", BASE + 8, 1);
    rd_lit("ovf_stat_hold", BASE, 1);
    ack();
    lit_req("ovf_ack", 0, 0);
    ov = 0;
    wr(BASE, 1); tick(); tick();
    rd_lit("ovf_clr", BASE, 0);
    lit_req("ovf_idle", 0, 0);
    m0 = 1; m1 = 1; tick(); tick();
    lit_req("pri_first", 1, 1);
    ack();
    lit_req("pri_ack1", 0, 1);
    wr(BASE, 2);
    lit_req("pri_gap0", 0, 1);
    tick();
    lit_req("pri_gap1", 0, 1);
    tick();
    lit_req("pri_second", 1, 2);
    ack(); wr(BASE, 4);
    m0 = 0; m1 = 0; tick(); tick();
    m0 = 1; m1 = 1; tick(); tick();
    lit_req("wd_req", 1, 1);
    bus.irq_ack = 1; bus.sys_addr = BASE; bus.sys_sw_value = 2; bus.sys_wr_en = 1;
    tick();
    bus.irq_ack = 0; bus.sys_wr_en = 0;
    lit_req("wd_drop", 0, 1);
    tick();
    lit_req("wd_idle_next", 1, 2);
    ack(); wr(BASE, 4);
    m0 = 0; m1 = 0; tick(); tick();
    wr(BASE + 4, 0);
    repeat (300) begin
      ov = 1; tick();
      ov = 0; tick();
    end
    rd_lit("cnt_sat", BASE + 8, 32'h0002_02FF);
    ov = 1;
    wr(BASE + 8, 32'h0);
    rd_lit("cnt_clr_rise", BASE + 8, 32'h1);
    ov = 0;
    wr(BASE, 7);
    wr(BASE + 4, 32'h107);
    m0 = 1; tick(); tick();
    lit_req("rst_pre", 1, 1);
    ack();
    rst = 1; tick(); rst = 0;
    lit_req("rst_mid", 0, 0);
    rd_lit("rst_mid_stat", BASE, 0);
    rd_lit("rst_mid_en", BASE + 4, 0);
    rd_lit("rst_mid_cnt", BASE + 8, 0);
    tick(); tick();
    rd_lit("rst_held_evt", BASE, 0);
    m0 = 0; tick();
    m0 = 1; tick();
    rd_lit("rst_rerise", BASE, 2);
    repeat (3000) begin
      rst = ($urandom_range(0, 399) == 0);
      clk_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) ov = ~ov;
      if ($urandom_range(0, 3) == 0) m0 = ~m0;
      if ($urandom_range(0, 3) == 0) m1 = ~m1;
      bus.irq_ack = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 4);
      bus.sys_addr = sel < 4 ? BASE + 32'(4 * sel) : $urandom;
      d = $urandom;
      if (sel == 1 && $urandom_range(0, 3) != 0) d = d | 32'h100;
      bus.sys_sw_value = d;
      bus.sys_wr_en = ($urandom_range(0, 4) == 0) && !(sel == 2 && $urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0; clk_en = 1; bus.sys_wr_en = 0; bus.irq_ack = 0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tmr_irq_ctrl_v1.md
# tmr_irq_ctrl_v1

Interrupt/event controller sitting directly downstream of the 32-bit timer wrapper. It consumes the timer's `match0_event`, `match1_event` and `ovf_event` outputs, which may stay high for several `sys_clk` cycles when the timer runs on a divided clock. It converts them into sticky, software-visible status flags and saturating event counters. It then drives a prioritised, acknowledged interrupt request towards the core, and exposes its control registers on the same SFR bus as the timer.

## Interface
- `DATA_WIDTH`, 32, SFR data width.
- `ADDR_WIDTH`, 32, SFR address width.
- `BASE_ADDR`, 0, address of IRQ_STAT. IRQ_EN is at BASE+4 and IRQ_CNT at BASE+8.
- `CNT_WIDTH`, 8, width of each event counter (at most 8).

Ports:
- `sys_clk`  in  1  single clock.
- `sys_rst`  in  1  synchronous, active-high reset.
- `sys_clk_en`  in  1  global enable; when low, every register holds.
- `sys_addr`  in  ADDR_WIDTH  SFR address.
- `sys_wr_en`  in  1  SFR write strobe.
- `sys_sw_value`  in  DATA_WIDTH  SFR write data.
- `sfr_rd_dout`  out  DATA_WIDTH  read data; 0 when `sys_addr` matches none of this block's registers (wired-OR safe).
- `match0_event`, `match1_event`, `ovf_event`  in  1 each  timer event levels, synchronous to `sys_clk`.
- `irq_ack`  in  1  core acknowledge, one-cycle pulse.
- `irq_req`  out  1  interrupt request.
- `irq_id`  out  2  source of the request: 0 = ovf, 1 = match0, 2 = match1.

## Operation
- **Edge detection.** Each event input is registered. A rise is `evt & ~evt_q`, so one set occurs per rising edge regardless of pulse length.
- **IRQ_STAT** (bits 2:0 = match1, match0, ovf):
  - A flag is set on a detected rise.
  - Software clears a flag by writing 1 to it (W1C).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **IRQ_EN:**
  - bits 2:0 enable each source individually.
  - bit 8 is the global enable GIE.
  - All other bits read as 0.
- **IRQ_CNT:**
  - bytes 0/1/2 count the ovf/match0/match1 rises.
  - Counters saturate at 2^CNT_WIDTH−1.
  - Any write to IRQ_CNT clears all counters. A rise in the same cycle as that write leaves the affected counter at 1.
- **Priority:** ovf > match0 > match1.
- **FSM** (states IDLE, REQ, WAIT_CLR):
  - IDLE: if GIE=1 and (STAT & EN) ≠ 0, latch the highest-priority pending id into `irq_id`, set `irq_req`=1, and go to REQ.
  - REQ, `irq_ack`=1: clear `irq_req` and go to WAIT_CLR.
  - REQ, GIE=0 or the latched flag/enable is cleared: withdraw (clear `irq_req`) and go to IDLE. If this happens in the same cycle as `irq_ack`, the withdraw wins.
  - WAIT_CLR: once the latched STAT bit reads 0, go to IDLE. Other pending sources are served afterwards in priority order.
- **`irq_ack`** has no effect outside REQ.
- **Reset mid-operation:** FSM returns to IDLE and all registers clear. An event input that is high during reset does not produce a rise on the first cycle after reset, because `evt_q` resets to 0 and the first cycle is masked.

## Timing
- **Reset values:**
  - `irq_req`=0, `irq_id`=0, `sfr_rd_dout`=0 unless an address matches.
  - STAT=0, EN=0, CNT=0, state IDLE, `evt_q`=0.
- **Latency:**
  - Event rise at cycle n → STAT bit and counter updated at n+1 → `irq_req` high at n+2.
  - `irq_ack` at cycle k → `irq_req` low at k+1.
  - A W1C in WAIT_CLR at cycle m → IDLE at m+2. The next request can be asserted at m+3.
- `sfr_rd_dout` is combinational from `sys_addr` and the registered state.
- SFR writes take effect at the next edge with `sys_clk_en`=1.
- With `sys_clk_en`=0, edges are not sampled and no state changes.

## Structure
- Add to `pkg_sfrs_definition`:
  - `tmr_irq_stat_t`, `tmr_irq_en_t`, `tmr_irq_cnt_t` packed structs.
  - `tmr_irq_state_e` (IDLE, REQ, WAIT_CLR).
  - Readable and writable bit-mask constants for the three registers.
- Sub-module `evt_rise_det_v1`: one register plus AND gate with a sync reset, instanced three times.

## Test plan
- Set EN=0x107. Hold `ovf_event` high for 16 cycles → STAT=0x1, CNT byte0=1, `irq_req` at n+2, `irq_id`=0.
- Raise `match0_event` and `match1_event` in the same cycle. Ack, W1C 0x2, ack, W1C 0x4 → `irq_id` sequence 1 then 2, with `irq_req` low between the two requests.
- In REQ, W1C the latched flag in the same cycle as `irq_ack` → `irq_req` drops and FSM returns to IDLE, not WAIT_CLR.
- Generate 300 `ovf` rises → CNT byte0=0xFF. Write IRQ_CNT in the same cycle as a rise → byte0=1.
- Assert `sys_rst` while in WAIT_CLR with `match0_event` held high → next cycle all zero. No new flag appears until `match0_event` falls and rises again.
